// File: rtl/spi_tx_queue.sv
// spi_tx_queue: word FIFO plus launch sequencer for the output-only SPI serializer.
// Words are popped one at a time into a registered TxData, announced with a one-clock
// TxStart, held until TxDone (or a timeout), then followed by a fixed idle gap.
module spi_tx_queue #(
  parameter int unsigned BITS       = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         WrEn,
  input  logic [BITS-1:0]              WrData,
  input  logic                         ClrErr,
  input  logic                         TxDone,
  output logic                         TxStart,
  output logic [BITS-1:0]              TxData,
  output logic                         Full,
  output logic                         Empty,
  output logic [$clog2(DEPTH+1)-1:0]   Count,
  output logic                         Busy,
  output logic                         Overflow,
  output logic                         TimeoutErr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  // Keep the gap counter at least one bit wide so GAP_CYCLES=0 still elaborates.
  localparam int unsigned GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StGap} state_e;

  state_e            state_q, state_d;
  logic [BITS-1:0]   mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [BITS-1:0]   tx_data_q;
  logic              tx_start_q;
  logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
  logic              overflow_q, timeout_err_q;

  logic              full, empty, push, drop, pop, timeout_evt;

  // Full/Empty come from the registered count, so a same-cycle pop never frees a slot.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = WrEn && !full;
  assign drop  = WrEn && full;

  // Sequencer next state: pop on leaving idle, arm timeout in launch, gap after done.
  always_comb begin
    state_d     = state_q;
    tmo_cnt_d   = tmo_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    pop         = 1'b0;
    timeout_evt = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        tmo_cnt_d = TW'(TIMEOUT);
        state_d   = StWait;
      end
      StWait: begin
        if (TxDone) begin
          if (GAP_CYCLES > 0) begin
            gap_cnt_d = GW'(GAP_CYCLES - 1);
            state_d   = StGap;
          end else begin
            state_d = StIdle;
          end
        end else if (tmo_cnt_q == TW'(1)) begin
          // Last permitted cycle passed without done: drop the word, no retry.
          timeout_evt = 1'b1;
          state_d     = StIdle;
        end else begin
          tmo_cnt_d = tmo_cnt_q - TW'(1);
        end
      end
      StGap: begin
        if (gap_cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q - GW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, pointers, count, output data and sticky error flags.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q       <= StIdle;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      tx_data_q     <= '0;
      tx_start_q    <= 1'b0;
      tmo_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      overflow_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_cnt_q  <= tmo_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      tx_start_q <= (state_d == StLaunch);
      count_q    <= count_q + CW'(push) - CW'(pop);
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + AW'(1);
        tx_data_q <= mem_q[rd_ptr_q];
      end
      // Set wins over a coincident clear.
      overflow_q    <= drop | (overflow_q & ~ClrErr);
      timeout_err_q <= timeout_evt | (timeout_err_q & ~ClrErr);
    end
  end

  // Storage array; contents need no reset since pointers and count gate every read.
  always_ff @(posedge Clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= WrData;
    end
  end

  assign TxStart    = tx_start_q;
  assign TxData     = tx_data_q;
  assign Full       = full;
  assign Empty      = empty;
  assign Count      = count_q;
  assign Busy       = (state_q != StIdle);
  assign Overflow   = overflow_q;
  assign TimeoutErr = timeout_err_q;

endmodule

// File: tb/tb_spi_tx_queue.sv
// Bench for spi_tx_queue: directed scenarios plus a randomized run against a
// timestamp-based reference model of the queue and launch timeline.
module tb_spi_tx_queue;

  localparam int unsigned DEPTH = 8;
  localparam int          GAP   = 4;
  localparam int          TMO   = 64;
  localparam int          BIG   = 32'h3fffffff;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        WrEn = 1'b0, ClrErr = 1'b0, TxDone = 1'b0;
  logic [31:0] WrData = '0;
  logic        TxStart, Full, Empty, Busy, Overflow, TimeoutErr;
  logic [31:0] TxData;
  logic [3:0]  Count;

  logic        WrEn0 = 1'b0, TxDone0 = 1'b0;
  logic [31:0] WrData0 = '0;
  logic        TxStart0, Full0, Empty0, Busy0, Overflow0, TimeoutErr0;
  logic [31:0] TxData0;
  logic [3:0]  Count0;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  spi_tx_queue #(.BITS(32), .DEPTH(DEPTH), .GAP_CYCLES(GAP), .TIMEOUT(TMO)) u_dut (
    .Clock(Clock), .Reset(Reset), .WrEn(WrEn), .WrData(WrData), .ClrErr(ClrErr),
    .TxDone(TxDone), .TxStart(TxStart), .TxData(TxData), .Full(Full), .Empty(Empty),
    .Count(Count), .Busy(Busy), .Overflow(Overflow), .TimeoutErr(TimeoutErr)
  );

  spi_tx_queue #(.BITS(32), .DEPTH(DEPTH), .GAP_CYCLES(0), .TIMEOUT(TMO)) u_dut0 (
    .Clock(Clock), .Reset(Reset), .WrEn(WrEn0), .WrData(WrData0), .ClrErr(ClrErr),
    .TxDone(TxDone0), .TxStart(TxStart0), .TxData(TxData0), .Full(Full0), .Empty(Empty0),
    .Count(Count0), .Busy(Busy0), .Overflow(Overflow0), .TimeoutErr(TimeoutErr0)
  );

  always #5 Clock = ~Clock;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge Clock);
    cyc++;
  endtask

  task automatic do_reset();
    WrEn = 0; ClrErr = 0; TxDone = 0; WrEn0 = 0; TxDone0 = 0;
    Reset = 1;
    tick();
    tick();
    Reset = 0;
    cyc = 0;
  endtask

  task automatic test_reset();
    Reset = 1;
    tick();
    tick();
    tests++;
    if ({Count, Empty, Full, TxStart, Busy, Overflow, TimeoutErr} !== {4'd0, 6'b100000}) begin
      fails++;
      $display("FAIL reset_flags: got %b want %b",
               {Count, Empty, Full, TxStart, Busy, Overflow, TimeoutErr}, {4'd0, 6'b100000});
    end
    tests++;
    if (TxData !== 32'h0) begin
      fails++; $display("FAIL reset_txdata: got %h want 0", TxData);
    end
    tests++;
    if ({Count0, Empty0, TxStart0, Busy0} !== {4'd0, 3'b100}) begin
      fails++; $display("FAIL reset_gap0: got %b want %b", {Count0, Empty0, TxStart0, Busy0}, 7'b0000100);
    end
    Reset = 0;
    cyc = 0;
  endtask

  task automatic test_single_word();
    do_reset();
    WrEn = 1; WrData = 32'hA5A5_1234;
    tick();
    WrEn = 0;
    tests++;
    if ({Count, Empty, TxStart} !== {4'd1, 2'b00}) begin
      fails++; $display("FAIL single_cycle1: got %b want %b", {Count, Empty, TxStart}, 6'b000100);
    end
    tick();
    tests++;
    if ({TxStart, Busy, Count, TxData} !== {2'b11, 4'd0, 32'hA5A5_1234}) begin
      fails++; $display("FAIL single_launch: got %h want %h", {TxStart, Busy, Count, TxData},
                        {2'b11, 4'd0, 32'hA5A5_1234});
    end
    tick();
    tests++;
    if (TxStart !== 1'b0) begin
      fails++; $display("FAIL single_pulse_width: got %b want 0", TxStart);
    end
    repeat (39) tick();
    TxDone = 1;
    tick();
    TxDone = 0;
    repeat (3) tick();
    tests++;
    if (Busy !== 1'b1) begin
      fails++; $display("FAIL single_gap_busy: got %b want 1", Busy);
    end
    tick();
    tests++;
    if ({Busy, TimeoutErr, TxData} !== {2'b00, 32'hA5A5_1234}) begin
      fails++; $display("FAIL single_idle: got %h want %h", {Busy, TimeoutErr, TxData},
                        {2'b00, 32'hA5A5_1234});
    end
  endtask

  // A dummy word stays in flight so the burst fills all eight slots.
  task automatic test_burst_fill();
    do_reset();
    WrEn = 1; WrData = 32'hDEAD;
    tick();
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) begin
        tests++;
        if ({Full, Count} !== {1'b0, 4'd7}) begin
          fails++; $display("FAIL burst_not_full: got %b want %b", {Full, Count}, 5'b00111);
        end
      end
      WrData = 32'(i);
      tick();
    end
    tests++;
    if ({Full, Count, TxData} !== {1'b1, 4'd8, 32'hDEAD}) begin
      fails++; $display("FAIL burst_full: got %h want %h", {Full, Count, TxData},
                        {1'b1, 4'd8, 32'hDEAD});
    end
    WrData = 32'h9;
    tick();
    WrEn = 0;
    tests++;
    if ({Overflow, Count} !== {1'b1, 4'd8}) begin
      fails++; $display("FAIL burst_overflow: got %b want %b", {Overflow, Count}, 5'b11000);
    end
    ClrErr = 1;
    tick();
    ClrErr = 0;
    tests++;
    if (Overflow !== 1'b0) begin
      fails++; $display("FAIL burst_clr: got %b want 0", Overflow);
    end
  endtask

  task automatic test_full_pop();
    TxDone = 1;
    tick();
    TxDone = 0;
    repeat (4) tick();
    tests++;
    if ({Busy, Full} !== 2'b01) begin
      fails++; $display("FAIL fullpop_pre: got %b want 01", {Busy, Full});
    end
    WrEn = 1; WrData = 32'h99;
    tick();
    WrEn = 0;
    tests++;
    if ({Overflow, Count, TxStart, TxData} !== {1'b1, 4'd7, 1'b1, 32'h1}) begin
      fails++; $display("FAIL fullpop: got %h want %h", {Overflow, Count, TxStart, TxData},
                        {1'b1, 4'd7, 1'b1, 32'h1});
    end
  endtask

  task automatic test_drain_order();
    int s, lat, n;
    s = cyc;
    for (int i = 1; i <= 8; i++) begin
      tests++;
      if ({TxStart, TxData} !== {1'b1, 32'(i)}) begin
        fails++; $display("FAIL drain_word%0d: got %h want %h", i, {TxStart, TxData}, {1'b1, 32'(i)});
      end
      lat = $urandom_range(1, 20);
      repeat (lat) tick();
      tests++;
      if (TxData !== 32'(i)) begin
        fails++; $display("FAIL drain_hold%0d: got %h want %h", i, TxData, 32'(i));
      end
      TxDone = 1;
      tick();
      TxDone = 0;
      if (i < 8) begin
        n = 0;
        while (!TxStart && n < 40) begin
          tick();
          n++;
        end
        tests++;
        if (!TxStart || (cyc - s) != lat + GAP + 2) begin
          fails++; $display("FAIL drain_spacing%0d: got %0d want %0d (start=%b)", i, cyc - s,
                            lat + GAP + 2, TxStart);
        end
        s = cyc;
      end
    end
    repeat (GAP) tick();
    tests++;
    if ({Busy, Empty, Count} !== {2'b01, 4'd0}) begin
      fails++; $display("FAIL drain_end: got %b want %b", {Busy, Empty, Count}, 6'b010000);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    WrEn = 1; WrData = 32'h11;
    tick();
    WrData = 32'h22;
    tick();
    WrEn = 0;
    tests++;
    if ({TxStart, TxData} !== {1'b1, 32'h11}) begin
      fails++; $display("FAIL tmo_launch: got %h want %h", {TxStart, TxData}, {1'b1, 32'h11});
    end
    repeat (TMO) tick();
    tests++;
    if ({TimeoutErr, Busy} !== 2'b01) begin
      fails++; $display("FAIL tmo_early: got %b want 01", {TimeoutErr, Busy});
    end
    tick();
    tests++;
    if ({TimeoutErr, Busy} !== 2'b10) begin
      fails++; $display("FAIL tmo_rise: got %b want 10", {TimeoutErr, Busy});
    end
    tick();
    tests++;
    if ({TxStart, TxData, TimeoutErr} !== {1'b1, 32'h22, 1'b1}) begin
      fails++; $display("FAIL tmo_next_launch: got %h want %h", {TxStart, TxData, TimeoutErr},
                        {1'b1, 32'h22, 1'b1});
    end
    ClrErr = 1;
    tick();
    ClrErr = 0;
    tests++;
    if (TimeoutErr !== 1'b0) begin
      fails++; $display("FAIL tmo_clr: got %b want 0", TimeoutErr);
    end
    // Second word times out on the cycle a clear arrives: the set must win.
    repeat (TMO - 1) tick();
    ClrErr = 1;
    tick();
    ClrErr = 0;
    tests++;
    if ({TimeoutErr, Busy} !== 2'b10) begin
      fails++; $display("FAIL tmo_set_wins: got %b want 10", {TimeoutErr, Busy});
    end
  endtask

  task automatic test_gap0_stray();
    do_reset();
    TxDone0 = 1;
    tick();
    TxDone0 = 0;
    tests++;
    if ({Busy0, TxStart0, Empty0} !== 3'b001) begin
      fails++; $display("FAIL gap0_stray_idle: got %b want 001", {Busy0, TxStart0, Empty0});
    end
    WrEn0 = 1; WrData0 = 32'h77;
    tick();
    WrData0 = 32'h88;
    tick();
    WrEn0 = 0;
    tests++;
    if ({TxStart0, TxData0, Count0} !== {1'b1, 32'h77, 4'd1}) begin
      fails++; $display("FAIL gap0_launch: got %h want %h", {TxStart0, TxData0, Count0},
                        {1'b1, 32'h77, 4'd1});
    end
    tick();
    tick();
    TxDone0 = 1;
    tick();
    TxDone0 = 0;
    tests++;
    if ({Busy0, TxStart0} !== 2'b00) begin
      fails++; $display("FAIL gap0_after_done: got %b want 00", {Busy0, TxStart0});
    end
    tick();
    tests++;
    if ({TxStart0, TxData0} !== {1'b1, 32'h88}) begin
      fails++; $display("FAIL gap0_relaunch: got %h want %h", {TxStart0, TxData0}, {1'b1, 32'h88});
    end
    TxDone0 = 1;  // lands in the launch cycle, not in wait
    tick();
    TxDone0 = 0;
    tests++;
    if (Busy0 !== 1'b1) begin
      fails++; $display("FAIL gap0_launch_done_ignored: got %b want 1", Busy0);
    end
    TxDone0 = 1;
    tick();
    TxDone0 = 0;
    tests++;
    if ({Busy0, Empty0} !== 2'b01) begin
      fails++; $display("FAIL gap0_final: got %b want 01", {Busy0, Empty0});
    end
  endtask

  task automatic test_reset_mid_wait();
    bit seen;
    do_reset();
    WrEn = 1;
    for (int i = 0; i < 4; i++) begin
      WrData = 32'h100 + 32'(i);
      tick();
    end
    WrEn = 0;
    tests++;
    if ({Count, Busy} !== {4'd3, 1'b1}) begin
      fails++; $display("FAIL rst_mid_pre: got %b want %b", {Count, Busy}, 5'b00111);
    end
    Reset = 1;
    tick();
    Reset = 0;
    tests++;
    if ({Count, Empty, Busy, TxStart, TxData} !== {4'd0, 3'b100, 32'h0}) begin
      fails++; $display("FAIL rst_mid: got %h want %h", {Count, Empty, Busy, TxStart, TxData},
                        {4'd0, 3'b100, 32'h0});
    end
    seen = 0;
    repeat (20) begin
      tick();
      if (TxStart) seen = 1;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++; $display("FAIL rst_mid_no_start: got %b want 0", seen);
    end
  endtask

  // Model: a word queue plus timestamps (launch cycle, cycle the sequencer is free again).
  task automatic test_random();
    logic [31:0] mq[$];
    logic [31:0] m_word;
    bit          m_ovf, m_tmo, idle, stray;
    int          m_free, m_start, done_at, sz;
    do_reset();
    mq.delete();
    m_word = '0; m_ovf = 0; m_tmo = 0; m_free = 0; m_start = -1; done_at = -1;
    for (int n = 0; n < 3000 && fails < 30; n++) begin
      sz = mq.size();
      tests++;
      if ({Count, Full, Empty} !== {4'(sz), sz == DEPTH, sz == 0}) begin
        fails++; $display("FAIL rnd_count@%0d: got %b want %b", cyc, {Count, Full, Empty},
                          {4'(sz), sz == DEPTH, sz == 0});
      end
      tests++;
      if (Busy !== (cyc < m_free)) begin
        fails++; $display("FAIL rnd_busy@%0d: got %b want %b", cyc, Busy, cyc < m_free);
      end
      tests++;
      if (TxStart !== (cyc == m_start)) begin
        fails++; $display("FAIL rnd_start@%0d: got %b want %b", cyc, TxStart, cyc == m_start);
      end
      tests++;
      if (TxData !== m_word) begin
        fails++; $display("FAIL rnd_data@%0d: got %h want %h", cyc, TxData, m_word);
      end
      tests++;
      if ({Overflow, TimeoutErr} !== {m_ovf, m_tmo}) begin
        fails++; $display("FAIL rnd_flags@%0d: got %b want %b", cyc, {Overflow, TimeoutErr},
                          {m_ovf, m_tmo});
      end
      // Serializer stand-in: random latency, sometimes never answers.
      if (TxStart) done_at = ($urandom_range(0, 7) == 0) ? -1 : cyc + $urandom_range(1, 30);
      stray  = ($urandom_range(0, 40) == 0);
      TxDone = (cyc == done_at) || stray;
      WrEn   = ($urandom_range(0, 2) == 0);
      WrData = $urandom;
      ClrErr = ($urandom_range(0, 19) == 0);
      idle = (cyc >= m_free);
      if (ClrErr) begin
        m_ovf = 0;
        m_tmo = 0;
      end
      if (m_start >= 0 && cyc > m_start && m_free == BIG) begin
        if (TxDone) m_free = cyc + 1 + GAP;
        else if (cyc == m_start + TMO) begin
          m_tmo  = 1;
          m_free = cyc + 1;
        end
      end
      if (idle && sz > 0) begin
        m_word  = mq.pop_front();
        m_start = cyc + 1;
        m_free  = BIG;
      end
      if (WrEn) begin
        if (sz == DEPTH) m_ovf = 1;
        else mq.push_back(WrData);
      end
      tick();
    end
    WrEn = 0; TxDone = 0; ClrErr = 0;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_burst_fill();
    test_full_pop();
    test_drain_order();
    test_timeout();
    test_gap0_stray();
    test_reset_mid_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
